// File: rtl/pcc_frame_packer_if.sv
// Beat-in / frame-out bundle between the bit producer, the frame packer and the pcc stage.
// Handshake: a transfer happens on a rising edge where valid && ready are both 1;
// valid must not depend on ready, and the payload is held while valid && !ready.
interface pcc_frame_packer_if #(
  parameter int POS_W = 2,
  parameter int NEG_W = 2,
  parameter int ID_W  = 4
);
  logic             in_valid;
  logic             in_ready;
  logic             in_bit;
  logic             in_neg;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [POS_W-1:0] out_pos;
  logic [NEG_W-1:0] out_neg;
  logic             out_ovf;
  logic [ID_W-1:0]  out_id;

  modport master (
    output in_valid, in_bit, in_neg, in_last, out_ready,
    input  in_ready, out_valid, out_pos, out_neg, out_ovf, out_id
  );

  modport slave (
    input  in_valid, in_bit, in_neg, in_last, out_ready,
    output in_ready, out_valid, out_pos, out_neg, out_ovf, out_id
  );
endinterface

// File: rtl/pcc_frame_packer.sv
// Packs tagged XNOR-product beats into pos/neg frame vectors for the pcc stage.
// One assembly buffer plus one output register, so the next frame fills while the current one waits.
module pcc_frame_packer #(
  parameter int POS_W = 2,
  parameter int NEG_W = 2,
  parameter int ID_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  pcc_frame_packer_if.slave     bus,
  output logic                  dbg_state
);
  localparam int PIW = $clog2(POS_W + 1);
  localparam int NIW = $clog2(NEG_W + 1);
  localparam logic [PIW-1:0] POS_CAP = PIW'(POS_W);
  localparam logic [NIW-1:0] NEG_CAP = NIW'(NEG_W);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_e;

  state_e           state, state_n;
  logic [POS_W-1:0] buf_pos, buf_pos_n, pos_upd, ld_pos;
  logic [NEG_W-1:0] buf_neg, buf_neg_n, neg_upd, ld_neg;
  logic [PIW-1:0]   pidx, pidx_n, pidx_upd;
  logic [NIW-1:0]   nidx, nidx_n, nidx_upd;
  logic             ovf, ovf_n, ovf_upd, ld_ovf;
  logic             out_valid_r, out_valid_n;
  logic [POS_W-1:0] out_pos_r, out_pos_n;
  logic [NEG_W-1:0] out_neg_r, out_neg_n;
  logic             out_ovf_r, out_ovf_n;
  logic [ID_W-1:0]  out_id_r, out_id_n, cnt, cnt_n;
  logic             accept, drain, slot_free, load;

  assign bus.in_ready  = (state == FILL) && !rst;
  assign bus.out_valid = out_valid_r;
  assign bus.out_pos   = out_pos_r;
  assign bus.out_neg   = out_neg_r;
  assign bus.out_ovf   = out_ovf_r;
  assign bus.out_id    = out_id_r;
  assign dbg_state     = state;

  assign accept    = bus.in_valid && bus.in_ready;
  assign drain     = out_valid_r && bus.out_ready;
  assign slot_free = !out_valid_r || bus.out_ready;

  always_comb begin
    // Buffer contents as they would be after applying the incoming beat.
    pos_upd  = buf_pos;
    neg_upd  = buf_neg;
    pidx_upd = pidx;
    nidx_upd = nidx;
    ovf_upd  = ovf;
    if (bus.in_neg) begin
      if (nidx == NEG_CAP) ovf_upd = 1'b1;
      else begin
        neg_upd  = buf_neg | (NEG_W'(bus.in_bit) << nidx);
        nidx_upd = nidx + NIW'(1);
      end
    end else begin
      if (pidx == POS_CAP) ovf_upd = 1'b1;
      else begin
        pos_upd  = buf_pos | (POS_W'(bus.in_bit) << pidx);
        pidx_upd = pidx + PIW'(1);
      end
    end
  end

  always_comb begin
    state_n     = state;
    buf_pos_n   = buf_pos;
    buf_neg_n   = buf_neg;
    pidx_n      = pidx;
    nidx_n      = nidx;
    ovf_n       = ovf;
    out_valid_n = out_valid_r;
    out_pos_n   = out_pos_r;
    out_neg_n   = out_neg_r;
    out_ovf_n   = out_ovf_r;
    out_id_n    = out_id_r;
    cnt_n       = cnt;
    load        = 1'b0;
    ld_pos      = pos_upd;
    ld_neg      = neg_upd;
    ld_ovf      = ovf_upd;
    case (state)
      FILL: begin
        if (accept) begin
          if (bus.in_last && slot_free) begin
            load      = 1'b1;
            buf_pos_n = '0;
            buf_neg_n = '0;
            pidx_n    = '0;
            nidx_n    = '0;
            ovf_n     = 1'b0;
          end else begin
            buf_pos_n = pos_upd;
            buf_neg_n = neg_upd;
            pidx_n    = pidx_upd;
            nidx_n    = nidx_upd;
            ovf_n     = ovf_upd;
            if (bus.in_last) state_n = HOLD;
          end
        end
      end
      HOLD: begin
        // The frozen buffer replaces the draining frame on the same edge.
        if (drain) begin
          load      = 1'b1;
          ld_pos    = buf_pos;
          ld_neg    = buf_neg;
          ld_ovf    = ovf;
          buf_pos_n = '0;
          buf_neg_n = '0;
          pidx_n    = '0;
          nidx_n    = '0;
          ovf_n     = 1'b0;
          state_n   = FILL;
        end
      end
      default: state_n = FILL;
    endcase
    if (load) begin
      out_valid_n = 1'b1;
      out_pos_n   = ld_pos;
      out_neg_n   = ld_neg;
      out_ovf_n   = ld_ovf;
      out_id_n    = cnt;
      cnt_n       = cnt + ID_W'(1);
    end else if (drain) begin
      out_valid_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      buf_pos     <= '0;
      buf_neg     <= '0;
      pidx        <= '0;
      nidx        <= '0;
      ovf         <= 1'b0;
      out_valid_r <= 1'b0;
      out_pos_r   <= '0;
      out_neg_r   <= '0;
      out_ovf_r   <= 1'b0;
      out_id_r    <= '0;
      cnt         <= '0;
    end else begin
      state       <= state_n;
      buf_pos     <= buf_pos_n;
      buf_neg     <= buf_neg_n;
      pidx        <= pidx_n;
      nidx        <= nidx_n;
      ovf         <= ovf_n;
      out_valid_r <= out_valid_n;
      out_pos_r   <= out_pos_n;
      out_neg_r   <= out_neg_n;
      out_ovf_r   <= out_ovf_n;
      out_id_r    <= out_id_n;
      cnt         <= cnt_n;
    end
  end
endmodule

// File: tb/tb_pcc_frame_packer.sv
// Directed bench for pcc_frame_packer: inputs change 1ns after the rising edge, outputs are checked there too.
module tb_pcc_frame_packer;
  logic clk = 1'b0;
  logic rst;
  logic dbg_state;
  int   tests = 0;
  int   fails = 0;

  pcc_frame_packer_if #(.POS_W(2), .NEG_W(2), .ID_W(4)) bus ();

  pcc_frame_packer #(.POS_W(2), .NEG_W(2), .ID_W(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and return 1ns after the edge that accepted it.
  task automatic beat(input logic b, input logic neg, input logic last);
    int waited;
    bus.in_valid = 1'b1;
    bus.in_bit   = b;
    bus.in_neg   = neg;
    bus.in_last  = last;
    waited = 0;
    while (!bus.in_ready && waited < 20) begin
      step();
      waited++;
    end
    tests++;
    if (!bus.in_ready) begin
      fails++;
      $display("FAIL beat_accept: in_ready=%0b required 1 within 20 cycles", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.in_neg = 1'b0; bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    step(); step();
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %0b want 0", bus.in_ready); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
    tests++; if (bus.out_pos !== 2'b00 || bus.out_neg !== 2'b00) begin fails++; $display("FAIL reset_data: pos=%b neg=%b want 00 00", bus.out_pos, bus.out_neg); end
    tests++; if (bus.out_ovf !== 1'b0 || bus.out_id !== 4'd0) begin fails++; $display("FAIL reset_ovf_id: ovf=%0b id=%0d want 0 0", bus.out_ovf, bus.out_id); end
    tests++; if (dbg_state !== 1'b0) begin fails++; $display("FAIL reset_state: got %0b want 0", dbg_state); end
    rst = 1'b0;
    #1;
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_ready: got %0b want 1", bus.in_ready); end
  endtask

  task automatic test_basic_frame();
    bus.out_ready = 1'b1;
    beat(1'b1, 1'b0, 1'b0);
    beat(1'b0, 1'b0, 1'b0);
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid: got %0b want 0", bus.out_valid); end
    beat(1'b1, 1'b1, 1'b0);
    beat(1'b1, 1'b1, 1'b1);
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %0b want 1", bus.out_valid); end
    tests++; if (bus.out_pos !== 2'b01 || bus.out_neg !== 2'b11) begin fails++; $display("FAIL basic_data: pos=%b neg=%b want 01 11", bus.out_pos, bus.out_neg); end
    tests++; if (bus.out_ovf !== 1'b0 || bus.out_id !== 4'd0) begin fails++; $display("FAIL basic_ovf_id: ovf=%0b id=%0d want 0 0", bus.out_ovf, bus.out_id); end
    step();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL basic_drain: out_valid=%0b want 0", bus.out_valid); end
  endtask

  task automatic test_single_beat();
    beat(1'b1, 1'b1, 1'b1);
    tests++; if (bus.out_valid !== 1'b1 || bus.out_pos !== 2'b00 || bus.out_neg !== 2'b01) begin
      fails++; $display("FAIL single_data: v=%0b pos=%b neg=%b want 1 00 01", bus.out_valid, bus.out_pos, bus.out_neg); end
    tests++; if (bus.out_ovf !== 1'b0 || bus.out_id !== 4'd1) begin fails++; $display("FAIL single_ovf_id: ovf=%0b id=%0d want 0 1", bus.out_ovf, bus.out_id); end
    step();
  endtask

  task automatic test_overflow();
    beat(1'b1, 1'b0, 1'b0);
    beat(1'b1, 1'b0, 1'b0);
    beat(1'b0, 1'b0, 1'b0);
    beat(1'b0, 1'b1, 1'b1);
    tests++; if (bus.out_pos !== 2'b11 || bus.out_neg !== 2'b00) begin fails++; $display("FAIL pos_ovf_data: pos=%b neg=%b want 11 00", bus.out_pos, bus.out_neg); end
    tests++; if (bus.out_ovf !== 1'b1 || bus.out_id !== 4'd2) begin fails++; $display("FAIL pos_ovf_flag: ovf=%0b id=%0d want 1 2", bus.out_ovf, bus.out_id); end
    // The next frame must start from a clean buffer and a cleared flag.
    beat(1'b1, 1'b0, 1'b1);
    tests++; if (bus.out_pos !== 2'b01 || bus.out_neg !== 2'b00 || bus.out_ovf !== 1'b0) begin
      fails++; $display("FAIL ovf_clear: pos=%b neg=%b ovf=%0b want 01 00 0", bus.out_pos, bus.out_neg, bus.out_ovf); end
    beat(1'b1, 1'b1, 1'b0);
    beat(1'b0, 1'b1, 1'b0);
    beat(1'b1, 1'b1, 1'b1);
    tests++; if (bus.out_neg !== 2'b01 || bus.out_ovf !== 1'b1 || bus.out_id !== 4'd4) begin
      fails++; $display("FAIL neg_ovf: neg=%b ovf=%0b id=%0d want 01 1 4", bus.out_neg, bus.out_ovf, bus.out_id); end
    step();
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    beat(1'b1, 1'b0, 1'b0);
    beat(1'b0, 1'b1, 1'b1);
    tests++; if (bus.out_valid !== 1'b1 || bus.out_pos !== 2'b01 || bus.out_id !== 4'd5) begin
      fails++; $display("FAIL bp_frame_a: v=%0b pos=%b id=%0d want 1 01 5", bus.out_valid, bus.out_pos, bus.out_id); end
    beat(1'b0, 1'b0, 1'b0);
    beat(1'b1, 1'b0, 1'b0);
    beat(1'b1, 1'b1, 1'b1);
    step(); step();
    tests++; if (bus.in_ready !== 1'b0 || dbg_state !== 1'b1) begin fails++; $display("FAIL bp_hold: in_ready=%0b state=%0b want 0 1", bus.in_ready, dbg_state); end
    tests++; if (bus.out_pos !== 2'b01 || bus.out_neg !== 2'b00 || bus.out_id !== 4'd5) begin
      fails++; $display("FAIL bp_stable: pos=%b neg=%b id=%0d want 01 00 5", bus.out_pos, bus.out_neg, bus.out_id); end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    #1;
    tests++; if (bus.out_valid !== 1'b1 || bus.out_pos !== 2'b10 || bus.out_neg !== 2'b01 || bus.out_id !== 4'd6) begin
      fails++; $display("FAIL bp_frame_b: v=%0b pos=%b neg=%b id=%0d want 1 10 01 6", bus.out_valid, bus.out_pos, bus.out_neg, bus.out_id); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL bp_release: in_ready=%0b want 1", bus.in_ready); end
    bus.out_ready = 1'b1;
    step();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain: out_valid=%0b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_id;
    logic [1:0] exp_pos;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      beat(logic'(i % 2), 1'b0, 1'b1);
      exp_id  = 4'((7 + i) % 16);
      exp_pos = (i % 2 == 1) ? 2'b01 : 2'b00;
      tests++; if (bus.out_valid !== 1'b1 || bus.out_id !== exp_id || bus.out_pos !== exp_pos) begin
        fails++; $display("FAIL b2b_frame%0d: v=%0b id=%0d pos=%b want 1 %0d %b", i, bus.out_valid, bus.out_id, bus.out_pos, exp_id, exp_pos); end
    end
    step();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain: out_valid=%0b want 0", bus.out_valid); end
  endtask

  task automatic test_mid_reset();
    bus.out_ready = 1'b0;
    beat(1'b1, 1'b1, 1'b1);
    beat(1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    tests++; if (bus.out_valid !== 1'b0 || dbg_state !== 1'b0) begin fails++; $display("FAIL mid_reset_clear: v=%0b state=%0b want 0 0", bus.out_valid, dbg_state); end
    bus.out_ready = 1'b1;
    beat(1'b1, 1'b0, 1'b1);
    tests++; if (bus.out_pos !== 2'b01 || bus.out_neg !== 2'b00 || bus.out_ovf !== 1'b0 || bus.out_id !== 4'd0) begin
      fails++; $display("FAIL mid_reset_frame: pos=%b neg=%b ovf=%0b id=%0d want 01 00 0 0", bus.out_pos, bus.out_neg, bus.out_ovf, bus.out_id); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_single_beat();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pcc_frame_packer.md
Name: pcc_frame_packer

Overview:
- Upstream feeder for the approximate popcount-compare (pcc) stage.
- Accepts a serial stream of XNOR-product bits, each tagged positive or negative. Packs one frame into a pos vector and a neg vector and hands the pair to the pcc stage over a valid/ready handshake.
- Double-buffered: one assembly buffer plus one output register, so frame N+1 assembles while frame N waits for the consumer.

Parameters:
- POS_W, 2, width of the pos vector (bits per frame tagged positive)
- NEG_W, 2, width of the neg vector (bits per frame tagged negative)
- ID_W, 4, width of the frame sequence counter

Ports:
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  packer can accept a beat
- in_bit  in  1  product bit
- in_neg  in  1  tag: 0 = pos group, 1 = neg group
- in_last  in  1  beat closes the current frame
- out_valid  out  1  output register holds a complete frame
- out_ready  in  1  pcc side consumes the frame
- out_pos  out  POS_W  packed pos bits; first pos beat lands in [0]
- out_neg  out  NEG_W  packed neg bits; first neg beat lands in [0]
- out_ovf  out  1  this frame carried more beats than capacity in some group
- out_id  out  ID_W  frame sequence number

Behaviour:
- Reset:
  - All outputs and registers go to zero: out_valid=0, out_pos=0, out_neg=0, out_ovf=0, out_id=0.
  - Assembly buffer cleared, pos/neg fill indices = 0, state = FILL.
  - in_ready=0 during the reset cycle.
  - Reset mid-frame discards the partial frame and any held frame; the frame counter restarts at 0.
- Beat acceptance:
  - A beat is accepted when in_valid && in_ready.
  - Pos beat: writes buf_pos[pidx], pidx++.
  - Neg beat: writes buf_neg[nidx], nidx++.
  - Beat beyond capacity (pidx==POS_W or nidx==NEG_W): data is dropped, the frame ovf flag is set, the index saturates.
- Short frames: unfilled positions are zero, i.e. treated as mismatches.
- States:
  - FILL: in_ready=1.
    - Accepted beat with in_last=1 completes the frame.
    - If the output slot is free this edge (out_valid==0, or out_valid&&out_ready), the frame moves into the output register at that edge. The last beat is included. Buffer and indices clear, ovf clears, state stays FILL.
    - Otherwise the frame is frozen and state goes to HOLD.
  - HOLD: in_ready=0.
    - On out_valid&&out_ready, the frozen frame moves into the output register at the same edge (out_valid stays 1). Buffer clears, state returns to FILL.
- Output register:
  - out_valid rises on the edge after the completing beat (latency 1 cycle from the in_last acceptance).
  - Output contents stay stable while out_valid && !out_ready.
  - out_valid falls only on a handshake with no replacement frame.
- out_id:
  - Each frame loaded into the output register carries the current counter value.
  - The counter increments per loaded frame and wraps modulo 2^ID_W.
- Simultaneous events:
  - Output drain and a new frame load in the same cycle gives back-to-back valid with no bubble.
  - Full throughput is 1 frame per cycle, with one beat per frame when every beat has in_last=1.
- Beat with in_last=1 and overflow: the frame still completes, with out_ovf=1.
- in_valid=0 or unaccepted beats cause no state change.

Test Plan:
- Reset, then beats (pos 1),(pos 0),(neg 1),(neg 1,last) with out_ready=1 -> next cycle out_valid=1, out_pos=2'b01, out_neg=2'b11, out_ovf=0, out_id=0.
- Single beat (neg 1,last) -> out_pos=2'b00, out_neg=2'b01, ovf=0.
- Frame with 3 pos beats 1,1,0 then (neg 0,last) -> out_pos=2'b11, out_neg=2'b00, out_ovf=1.
- out_ready=0; complete frame A, then frame B -> after B's last beat in_ready=0 and out_pos/out_neg hold A. Then out_ready=1 for one cycle -> next cycle shows B with id A+1, and in_ready=1.
- in_last on every beat, out_ready=1, 20 frames -> out_valid continuously 1, out_id wraps 15->0.
- Assert rst mid-frame after 1 pos beat, then feed (pos 1,last) -> out_pos=2'b01, out_id=0.
